// File: rtl/dafx_i2s_tx.sv
// I2S DAC-side transmitter: one-frame holding register feeding sclk/lrclk/sdata generated from clk.
// Define DAFX_I2S_TX_REPEAT_EN to resend the previous frame on underflow instead of silence.
module dafx_i2s_tx #(
    parameter int AUDIO_WIDTH_P = 24,
    parameter int SLOT_BITS_P   = 32,
    parameter int SCLK_DIV_P    = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cr_enable,
    input  logic [AUDIO_WIDTH_P-1:0] s_left,
    input  logic [AUDIO_WIDTH_P-1:0] s_right,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     i2s_sclk,
    output logic                     i2s_lrclk,
    output logic                     i2s_sdata,
    output logic                     sr_underflow,
    output logic [31:0]              sr_frame_cnt
);
    localparam int BW = $clog2(2 * SLOT_BITS_P);
    localparam int CW = (SCLK_DIV_P > 1) ? $clog2(SCLK_DIV_P) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state;
    logic [CW-1:0]            div_cnt;
    logic [BW-1:0]            bit_idx;
    logic                     hold_full;
    logic [AUDIO_WIDTH_P-1:0] hold_l;
    logic [AUDIO_WIDTH_P-1:0] hold_r;
    logic [AUDIO_WIDTH_P-1:0] sh_l;
    logic [AUDIO_WIDTH_P-1:0] sh_r;
    logic [BW-1:0]            bit_nxt;
    logic [BW-1:0]            pos_nxt;
    logic                     right_nxt;
    logic                     sdata_nxt;

    assign s_ready = ~hold_full;

    // Next bit position and its data bit; slot position 0 is the I2S one-bit delay.
    always_comb begin
        bit_nxt   = (bit_idx == BW'(2 * SLOT_BITS_P - 1)) ? '0 : bit_idx + BW'(1);
        right_nxt = (bit_nxt >= BW'(SLOT_BITS_P));
        pos_nxt   = right_nxt ? bit_nxt - BW'(SLOT_BITS_P) : bit_nxt;
        sdata_nxt = 1'b0;
        for (int i = 0; i < AUDIO_WIDTH_P; i++) begin
            if (pos_nxt == BW'(AUDIO_WIDTH_P - i))
                sdata_nxt = right_nxt ? sh_r[i] : sh_l[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bit_idx      <= '0;
            hold_full    <= 1'b0;
            hold_l       <= '0;
            hold_r       <= '0;
            sh_l         <= '0;
            sh_r         <= '0;
            i2s_sclk     <= 1'b0;
            i2s_lrclk    <= 1'b0;
            i2s_sdata    <= 1'b0;
            sr_underflow <= 1'b0;
            sr_frame_cnt <= '0;
        end else begin
            sr_underflow <= 1'b0;
            // Accept and consume are exclusive: accept needs empty, consume needs full.
            if (s_valid && s_ready) begin
                hold_full <= 1'b1;
                hold_l    <= s_left;
                hold_r    <= s_right;
            end
            case (state)
                IDLE: begin
                    i2s_sclk  <= 1'b0;
                    i2s_lrclk <= 1'b0;
                    i2s_sdata <= 1'b0;
                    if (cr_enable) begin
                        state     <= RUN;
                        i2s_sclk  <= 1'b1;
                        i2s_lrclk <= 1'b1;
                        bit_idx   <= BW'(2 * SLOT_BITS_P - 1);
                        div_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (div_cnt == CW'(SCLK_DIV_P - 1)) begin
                        div_cnt  <= '0;
                        i2s_sclk <= ~i2s_sclk;
                        if (i2s_sclk) begin
                            if (bit_nxt == '0 && !cr_enable) begin
                                state     <= IDLE;
                                i2s_lrclk <= 1'b0;
                                i2s_sdata <= 1'b0;
                            end else begin
                                bit_idx   <= bit_nxt;
                                i2s_lrclk <= right_nxt;
                                i2s_sdata <= sdata_nxt;
                                if (bit_nxt == '0) begin
                                    if (hold_full) begin
                                        sh_l         <= hold_l;
                                        sh_r         <= hold_r;
                                        hold_full    <= 1'b0;
                                        sr_frame_cnt <= sr_frame_cnt + 32'd1;
                                    end else begin
                                        sr_underflow <= 1'b1;
`ifdef DAFX_I2S_TX_REPEAT_EN
                                        sh_l <= sh_l;
                                        sh_r <= sh_r;
`else
                                        sh_l <= '0;
                                        sh_r <= '0;
`endif
                                    end
                                end
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dafx_i2s_tx.sv
// Directed bench for dafx_i2s_tx: decodes the serial stream on rising sclk and compares frames.
`timescale 1ns/1ps
module tb_dafx_i2s_tx;
    localparam int LIM = 6000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cr_enable = 1'b0;
    logic [23:0] s_left = '0;
    logic [23:0] s_right = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        i2s_sclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic        sr_underflow;
    logic [31:0] sr_frame_cnt;

    always #4 clk = ~clk;

    dafx_i2s_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cr_enable    (cr_enable),
        .s_left       (s_left),
        .s_right      (s_right),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .i2s_sclk     (i2s_sclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .sr_underflow (sr_underflow),
        .sr_frame_cnt (sr_frame_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Receiver model: samples sdata on rising sclk, slot position restarts on each lrclk change.
    int          mon_pos = 0;
    int          mon_rise = 0;
    int          mon_uf = 0;
    int          mon_pad_err = 0;
    int          mon_cyc = 0;
    int          mon_period = 0;
    int          mon_high = 0;
    logic        mon_lr = 1'b1;
    logic        mon_sclk_q = 1'b0;
    logic [23:0] mon_word = '0;
    logic [23:0] mon_lw = '0;
    logic [47:0] frames[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_pos = 0; mon_rise = 0; mon_uf = 0; mon_pad_err = 0; mon_cyc = 0;
            mon_lr = 1'b1; mon_sclk_q = 1'b0; mon_word = '0; mon_lw = '0;
            frames.delete();
        end else begin
            mon_cyc++;
            if (i2s_sclk && !mon_sclk_q) begin
                mon_period = mon_cyc;
                mon_cyc = 0;
                mon_rise++;
                if (i2s_lrclk != mon_lr) mon_pos = 0;
                else mon_pos++;
                mon_lr = i2s_lrclk;
                if (mon_pos >= 1 && mon_pos <= 24) mon_word = {mon_word[22:0], i2s_sdata};
                else if (mon_pos <= 31 && i2s_sdata) mon_pad_err++;
                if (mon_pos == 31) begin
                    if (!i2s_lrclk) mon_lw = mon_word;
                    else frames.push_back({mon_lw, mon_word});
                end
            end
            if (!i2s_sclk && mon_sclk_q) mon_high = mon_cyc;
            if (sr_underflow) mon_uf++;
            mon_sclk_q = i2s_sclk;
        end
    end

    task automatic send(input logic [23:0] l, input logic [23:0] r, input logic keep);
        int n = 0;
        @(negedge clk);
        s_left = l; s_right = r; s_valid = 1'b1;
        while (!s_ready && n < LIM) begin @(negedge clk); n++; end
        check("send_timeout", 64'(n < LIM), 64'd1);
        @(posedge clk); #1;
        if (!keep) s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int cnt, input string tag);
        int n = 0;
        while (frames.size() < cnt && n < LIM) begin @(negedge clk); n++; end
        check(tag, 64'(n < LIM), 64'd1);
    endtask

    logic [47:0] exp2;
    int          n;

    initial begin
`ifdef DAFX_I2S_TX_REPEAT_EN
        exp2 = {24'hA5A5A5, 24'h5A5A5A};
`else
        exp2 = '0;
`endif
        // Reset and idle
        repeat (5) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(s_ready), 64'd1);
        check("rst_sclk", 64'(i2s_sclk), 64'd0);
        check("rst_lrclk", 64'(i2s_lrclk), 64'd0);
        check("rst_sdata", 64'(i2s_sdata), 64'd0);
        check("rst_uf", 64'(sr_underflow), 64'd0);
        check("rst_cnt", 64'(sr_frame_cnt), 64'd0);
        repeat (1000) @(negedge clk);
        check("idle_rises", 64'(mon_rise), 64'd0);
        check("idle_sclk", 64'(i2s_sclk), 64'd0);

        // Single frame, preloaded while idle
        send(24'hA5A5A5, 24'h5A5A5A, 1'b0);
        check("preload_ready", 64'(s_ready), 64'd0);
        cr_enable = 1'b1;
        wait_frames(1, "frame1_timeout");
        check("frame1_data", 64'(frames[0]), 64'h0000_A5A5A5_5A5A5A);
        check("frame1_cnt", 64'(sr_frame_cnt), 64'd1);
        check("frame1_ready", 64'(s_ready), 64'd1);
        check("frame1_uf", 64'(mon_uf), 64'd0);
        check("sclk_period", 64'(mon_period), 64'd40);
        check("sclk_high", 64'(mon_high), 64'd20);

        // Underflow at second frame start
        n = 0;
        while (mon_uf < 1 && n < LIM) begin @(negedge clk); n++; end
        check("uf_timeout", 64'(n < LIM), 64'd1);

        // Back-pressured stream of 10 frames
        fork
            begin
                for (int k = 0; k < 10; k++)
                    send(24'hF00000 + 24'(k), 24'h0F0F00 + 24'(k), k != 9);
            end
        join_none

        wait_frames(2, "frame2_timeout");
        check("frame2_data", 64'(frames[1]), 64'(exp2));
        check("frame2_uf", 64'(mon_uf), 64'd1);
        check("frame2_cnt", 64'(sr_frame_cnt), 64'd1);

        // Disable at b=40 of the twelfth frame
        n = 0;
        while (!(frames.size() == 11 && mon_lr && mon_pos == 8) && n < 40000) begin
            @(negedge clk); n++;
        end
        check("b40_timeout", 64'(n < 40000), 64'd1);
        cr_enable = 1'b0;
        wait_frames(12, "frame12_timeout");
        for (int k = 0; k < 10; k++)
            check($sformatf("stream%0d", k), 64'(frames[2 + k]),
                  64'({24'hF00000 + 24'(k), 24'h0F0F00 + 24'(k)}));
        check("stream_uf", 64'(mon_uf), 64'd1);
        check("stream_period", 64'(mon_period), 64'd40);
        repeat (200) @(negedge clk);
        check("dis_sclk", 64'(i2s_sclk), 64'd0);
        check("dis_lrclk", 64'(i2s_lrclk), 64'd0);
        check("dis_sdata", 64'(i2s_sdata), 64'd0);
        check("dis_cnt", 64'(sr_frame_cnt), 64'd11);
        check("dis_uf", 64'(mon_uf), 64'd1);
        check("dis_frames", 64'(frames.size()), 64'd12);
        check("pad_bits", 64'(mon_pad_err), 64'd0);

        // Reset mid-frame with a frame held
        send(24'h123456, 24'h654321, 1'b0);
        cr_enable = 1'b1;
        n = 0;
        while (sr_frame_cnt != 32'd12 && n < LIM) begin @(negedge clk); n++; end
        check("load12_timeout", 64'(n < LIM), 64'd1);
        send(24'h0000FF, 24'hFF0000, 1'b0);
        n = 0;
        while (!(frames.size() == 12 && !mon_lr && mon_pos == 10) && n < LIM) begin
            @(negedge clk); n++;
        end
        check("b10_timeout", 64'(n < LIM), 64'd1);
        check("held_ready", 64'(s_ready), 64'd0);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_sclk", 64'(i2s_sclk), 64'd0);
        check("mrst_lrclk", 64'(i2s_lrclk), 64'd0);
        check("mrst_sdata", 64'(i2s_sdata), 64'd0);
        check("mrst_ready", 64'(s_ready), 64'd1);
        check("mrst_cnt", 64'(sr_frame_cnt), 64'd0);
        check("mrst_uf", 64'(sr_underflow), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_frames(1, "rerun_timeout");
        check("rerun_data", 64'(frames[0]), 64'd0);
        check("rerun_uf", 64'(mon_uf), 64'd1);
        check("rerun_cnt", 64'(sr_frame_cnt), 64'd0);
        check("rerun_pad", 64'(mon_pad_err), 64'd0);
        cr_enable = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dafx_i2s_tx.md
Name: dafx_i2s_tx

Overview:
- I2S transmitter at the DAC end of the dafx audio path; the complement of the ADC-side I2S receiver.
- Accepts one stereo frame of signed 24-bit samples per handshake from the effects pipeline.
- Generates bit clock (sclk), word select (lrclk) and serial data (sdata) from the 125 MHz system clock.
- One-frame holding register decouples the pipeline from the serial timing; underflow is flagged.

Parameters:
- AUDIO_WIDTH_P, 24, sample width in bits; must be <= SLOT_BITS_P-1.
- SLOT_BITS_P, 32, sclk periods per channel slot; a frame is 2*SLOT_BITS_P sclk periods.
- SCLK_DIV_P, 20, system clock cycles per sclk half-period; must be >= 2.

Ports:
- clk  in  1  system clock, 125 MHz.
- rst_n  in  1  synchronous reset, active low.
- cr_enable  in  1  transmit enable.
- s_left  in  AUDIO_WIDTH_P  left sample, two's complement.
- s_right  in  AUDIO_WIDTH_P  right sample, two's complement.
- s_valid  in  1  frame valid.
- s_ready  out  1  holding register empty.
- i2s_sclk  out  1  bit clock.
- i2s_lrclk  out  1  word select; 0 = left, 1 = right.
- i2s_sdata  out  1  serial data.
- sr_underflow  out  1  one-cycle pulse when a frame starts with no sample held.
- sr_frame_cnt  out  32  frames transmitted; wraps at 2^32.

Behaviour:
- Clock and reset: single clock domain (clk). rst_n is synchronous and active low.
- Reset values: s_ready=1, i2s_sclk=0, i2s_lrclk=0, i2s_sdata=0, sr_underflow=0, sr_frame_cnt=0. State is IDLE, holding register is empty, shift registers are zero.
- Reset mid-frame: all outputs return to their reset values on the next clk edge; the partial frame is abandoned; a held sample is discarded.
- Handshake: a transfer occurs when s_valid && s_ready at a clk edge. The frame is captured into the holding register and s_ready=0 from the next cycle. s_ready returns to 1 in the cycle after the holding register is consumed.
- IDLE state:
  - s_ready still works; one frame may be preloaded.
  - sclk, lrclk and sdata are held at 0.
  - cr_enable=1 moves to RUN on the next edge.
- Entering RUN: sclk=1, bit index b=2*SLOT_BITS_P-1, lrclk=1, half-period counter=0.
- Half-period counter: counts 0..SCLK_DIV_P-1; sclk toggles on each wrap.
- Falling sclk edge (every internal event happens here):
  - b increments modulo 2*SLOT_BITS_P.
  - lrclk = (b >= SLOT_BITS_P).
  - sdata updates. With slot position p = b mod SLOT_BITS_P: p=0 gives 0, p=1..AUDIO_WIDTH_P gives sample bit AUDIO_WIDTH_P-p (MSB first), remaining p give 0. This is the standard I2S one-bit delay after the lrclk edge.
- Frame load (falling edge where b becomes 0):
  - Holding register full: left/right copied into the shift registers, holding register emptied, sr_frame_cnt+1.
  - Holding register empty: shift registers loaded with zero, sr_underflow pulses for one clk, sr_frame_cnt unchanged.
  - Load and accept in the same cycle with the register empty: counts as underflow; the accepted frame lands in the holding register for the next frame.
- Disable: cr_enable=0 takes effect only at frame end. The falling edge where b would become 0 instead returns to IDLE with outputs at 0 and no load. A frame is never truncated.
- Timing with defaults: sclk = 3.125 MHz, fs ≈ 48.83 kHz.
- Latency: first sclk falling edge occurs SCLK_DIV_P cycles after RUN entry. The MSB of the left sample appears one sclk period later.

Optional Feature:
- Macro: DAFX_I2S_TX_REPEAT_EN.
- Defined: an underflow reloads the previously transmitted frame (last shift-register contents) instead of zero. sr_underflow still pulses. After reset the "previous frame" is zero.
- Undefined: an underflow transmits zero samples.

Test Plan:
- Reset and idle: hold rst_n=0 for 5 cycles, then release with cr_enable=0 -> all outputs at reset values, s_ready=1, sclk static for 1000 cycles.
- Single frame: preload L=24'hA5A5A5, R=24'h5A5A5A, then cr_enable=1 -> sclk period 40 clk; on lrclk=0 the slot bits 1..24 decode to A5A5A5, on lrclk=1 to 5A5A5A; pad bits 0; sr_frame_cnt=1; s_ready=1 after the load.
- Underflow: no second frame supplied -> exactly one sr_underflow pulse at the second frame start; the frame decodes to 0 (or to A5A5A5/5A5A5A with DAFX_I2S_TX_REPEAT_EN); sr_frame_cnt stays 1.
- Back-pressure: s_valid held high with an incrementing counter pattern for 10 frames -> one transfer per frame, no drops or duplicates, 10 decoded frames match in order, sr_underflow never pulses.
- Disable mid-frame: drop cr_enable at b=40 -> frame completes through b=63; sclk, lrclk and sdata go to 0 at the next frame boundary; no load occurs.
- Reset mid-frame: assert rst_n=0 at b=10 with a frame held -> outputs reach reset values on the next edge; s_ready=1; after re-enable, frame 0 is an underflow.
